// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Write-back port bundle: pipeline result, accelerator result
//            queue handshake and registered register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] alu_op_in;
    logic [DATA_W-1:0] ld_op_in;
    logic              wr_mux_sel_out_sync;
    logic              cx_valid;
    logic [ADDR_W-1:0] cx_rd;
    logic [DATA_W-1:0] cx_data;
    logic              cx_ready;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output pipe_wr_en, pipe_rd, alu_op_in, ld_op_in, wr_mux_sel_out_sync,
        output cx_valid, cx_rd, cx_data,
        input  cx_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_wr_en, pipe_rd, alu_op_in, ld_op_in, wr_mux_sel_out_sync,
        input  cx_valid, cx_rd, cx_data,
        output cx_ready, pipe_stall, rf_we, rf_waddr, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Arbitrates the register-file write port between the pipeline
//            result and queued accelerator results, with a starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int CQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_arbiter_if.slave bus
);
    localparam int c_ptr_w = $clog2(CQ_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(CQ_DEPTH);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_LIMIT);

    logic              r_q_valid [CQ_DEPTH];
    logic [ADDR_W-1:0] r_q_rd    [CQ_DEPTH];
    logic [DATA_W-1:0] r_q_data  [CQ_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_stv_w-1:0] r_starve;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_stall;
    logic              w_grant_pipe;
    logic              w_grant_cx;
    logic [DATA_W-1:0] w_pipe_data;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_depth);
    assign w_push       = bus.cx_valid && !w_full;
    assign w_stall      = (r_starve == c_starve_max) && !w_empty;
    assign w_grant_pipe = !w_stall && bus.pipe_wr_en;
    // A stall forces the head out; otherwise the queue only wins an idle pipeline.
    assign w_grant_cx   = w_stall || (!bus.pipe_wr_en && !w_empty);
    assign w_pipe_data  = bus.wr_mux_sel_out_sync ? bus.ld_op_in : bus.alu_op_in;

    assign bus.cx_ready   = !w_full;
    assign bus.pipe_stall = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CQ_DEPTH; i++) begin
                r_q_valid[i] <= 1'b0;
                r_q_rd[i]    <= '0;
                r_q_data[i]  <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            // Older accelerator results to the same register are now stale;
            // the push below is ordered after this so a same-cycle entry survives.
            if (w_grant_pipe) begin
                for (int i = 0; i < CQ_DEPTH; i++) begin
                    if (r_q_rd[i] == bus.pipe_rd) begin
                        r_q_valid[i] <= 1'b0;
                    end
                end
            end

            if (w_push) begin
                r_q_valid[r_wr_ptr] <= 1'b1;
                r_q_rd[r_wr_ptr]    <= bus.cx_rd;
                r_q_data[r_wr_ptr]  <= bus.cx_data;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end

            if (w_grant_cx) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_grant_cx})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_grant_pipe) begin
                if (!w_empty && (r_starve != c_starve_max)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                r_starve <= '0;
            end

            if (w_grant_pipe) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= bus.pipe_rd;
                bus.rf_wdata <= w_pipe_data;
            end else if (w_grant_cx) begin
                bus.rf_we    <= r_q_valid[r_rd_ptr];
                bus.rf_waddr <= r_q_rd[r_rd_ptr];
                bus.rf_wdata <= r_q_data[r_rd_ptr];
            end else begin
                bus.rf_we    <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed stimulus with a cycle-stamped write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    wb_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    wb_arbiter #(
        .DATA_W      (16),
        .ADDR_W      (3),
        .CQ_DEPTH    (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed write must be the next expected one, at the expected cycle.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h want no write",
                         cyc, bus.rf_waddr, bus.rf_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
                    bad++;
                    $display("FAIL rf_write got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             cyc, bus.rf_waddr, bus.rf_wdata, e.cyc, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int c, input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        bus.pipe_wr_en          = 1'b0;
        bus.pipe_rd             = 3'd0;
        bus.alu_op_in           = 16'h0000;
        bus.ld_op_in            = 16'h0000;
        bus.wr_mux_sel_out_sync = 1'b0;
        bus.cx_valid            = 1'b0;
        bus.cx_rd               = 3'd0;
        bus.cx_data             = 16'h0000;
    endtask

    task automatic pipe(input logic [2:0] rd, input logic [15:0] alu,
                        input logic [15:0] ld, input logic sel);
        bus.pipe_wr_en          = 1'b1;
        bus.pipe_rd             = rd;
        bus.alu_op_in           = alu;
        bus.ld_op_in            = ld;
        bus.wr_mux_sel_out_sync = sel;
    endtask

    task automatic push(input logic [2:0] rd, input logic [15:0] d);
        bus.cx_valid = 1'b1;
        bus.cx_rd    = rd;
        bus.cx_data  = d;
    endtask

    initial begin
        int  p;
        logic accept;
        total = 0;
        bad   = 0;

        // Reset with random inputs
        rst                     = 1'b1;
        bus.pipe_wr_en          = 1'($urandom);
        bus.pipe_rd             = 3'($urandom);
        bus.alu_op_in           = 16'($urandom);
        bus.ld_op_in            = 16'($urandom);
        bus.wr_mux_sel_out_sync = 1'($urandom);
        bus.cx_valid            = 1'($urandom);
        bus.cx_rd               = 3'($urandom);
        bus.cx_data             = 16'($urandom);
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk("rst_we",     32'(bus.rf_we),      32'd0);
        chk("rst_waddr",  32'(bus.rf_waddr),   32'd0);
        chk("rst_wdata",  32'(bus.rf_wdata),   32'd0);
        chk("rst_ready",  32'(bus.cx_ready),   32'd1);
        chk("rst_stall",  32'(bus.pipe_stall), 32'd0);
        tick();

        // Mux select: ALU then LOAD
        pipe(3'd3, 16'h1234, 16'hBEEF, 1'b0);
        expect_wr(cyc + 1, 3'd3, 16'h1234);
        tick();
        pipe(3'd3, 16'h1234, 16'hBEEF, 1'b1);
        expect_wr(cyc + 1, 3'd3, 16'hBEEF);
        tick();
        idle();
        tick();
        tick();

        // Accelerator path: visible two cycles after acceptance
        push(3'd5, 16'hA5A5);
        chk("acc_ready", 32'(bus.cx_ready), 32'd1);
        expect_wr(cyc + 2, 3'd5, 16'hA5A5);
        tick();
        idle();
        repeat (4) tick();

        // Starvation: 4 pipe writes, one stall that drains the queue, then resume
        push(3'd6, 16'h0F0F);
        tick();
        idle();
        for (int j = 1; j <= 6; j++) begin
            pipe(3'd1, 16'h5555, 16'hAAAA, 1'b0);
            chk("starve_stall", 32'(bus.pipe_stall), 32'(j == 5));
            if (j == 5) expect_wr(cyc + 1, 3'd6, 16'h0F0F);
            else        expect_wr(cyc + 1, 3'd1, 16'h5555);
            tick();
        end
        idle();
        repeat (3) tick();

        // Backpressure: three pushes into a depth-2 queue under continuous pipe writes
        p = 0;
        for (int j = 0; j < 17; j++) begin
            pipe(3'd1, 16'h7777, 16'h0000, 1'b0);
            bus.cx_valid = (p < 3);
            bus.cx_rd    = 3'(3 + p);
            bus.cx_data  = 16'(16'h0333 + 16'h0111 * p);
            if (j <= 6) chk("full_ready", 32'(bus.cx_ready), 32'(j < 2 || j == 6));
            chk("full_stall", 32'(bus.pipe_stall), 32'(j == 5 || j == 10 || j == 15));
            if (j == 5 || j == 10 || j == 15) begin
                int q;
                q = j / 5 - 1;
                expect_wr(cyc + 1, 3'(3 + q), 16'(16'h0333 + 16'h0111 * q));
            end else begin
                expect_wr(cyc + 1, 3'd1, 16'h7777);
            end
            accept = bus.cx_valid && bus.cx_ready;
            tick();
            if (accept) p++;
        end
        idle();
        chk("full_accepted", 32'(p), 32'd3);
        repeat (3) tick();

        // Ordering drop: the newer pipeline value wins, stale entry pops silently
        push(3'd2, 16'h1111);
        tick();
        idle();
        pipe(3'd2, 16'h2222, 16'h0000, 1'b0);
        expect_wr(cyc + 1, 3'd2, 16'h2222);
        tick();
        idle();
        tick();
        chk("drop_no_write", 32'(bus.rf_we), 32'd0);
        repeat (2) tick();

        // Same-cycle push to the pipeline's register is kept
        pipe(3'd3, 16'h0303, 16'h0000, 1'b0);
        push(3'd3, 16'h3333);
        expect_wr(cyc + 1, 3'd3, 16'h0303);
        expect_wr(cyc + 2, 3'd3, 16'h3333);
        tick();
        idle();
        repeat (3) tick();

        // Reset with two entries queued discards them
        pipe(3'd1, 16'h9999, 16'h0000, 1'b0);
        push(3'd4, 16'h4444);
        expect_wr(cyc + 1, 3'd1, 16'h9999);
        tick();
        pipe(3'd1, 16'h9999, 16'h0000, 1'b0);
        push(3'd7, 16'h7777);
        expect_wr(cyc + 1, 3'd1, 16'h9999);
        tick();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(bus.cx_ready),   32'd1);
        chk("mid_rst_stall", 32'(bus.pipe_stall), 32'd0);
        repeat (6) tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back port controller for the register file. It arbitrates the single register-file write port between the in-order pipeline result and results returned asynchronously by the on-chip cryptographic accelerator. For the pipeline result it performs the ALU/LOAD selection itself. Accelerator results are buffered in a small queue, and a starvation guard briefly stalls the pipeline so they drain.

## Interface
- DATA_W, 16, write data width
- ADDR_W, 3, register address width
- CQ_DEPTH, 2, accelerator result queue depth (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive denied cycles before pipeline stall (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_wr_en  in  1  pipeline has a write-back this cycle
- pipe_rd  in  ADDR_W  pipeline destination register
- alu_op_in  in  DATA_W  ALU result
- ld_op_in  in  DATA_W  LOAD result
- wr_mux_sel_out_sync  in  1  0 = ALU result, 1 = LOAD result
- cx_valid  in  1  accelerator result valid
- cx_rd  in  ADDR_W  accelerator destination register
- cx_data  in  DATA_W  accelerator result
- cx_ready  out  1  queue can accept (= not full)
- pipe_stall  out  1  pipeline must hold its write-back this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)

## Operation
- **Queue:** CQ_DEPTH-entry FIFO of {valid, rd, data}.
  - Push when cx_valid && cx_ready.
  - cx_ready = !full. There is no push-on-pop bypass, so a full queue refuses even if a pop occurs that cycle.
  - A push into an empty queue is not eligible for grant in the same cycle.
- **Starve counter:** starve_cnt, 0..STARVE_LIMIT.
  - pipe_stall = (starve_cnt == STARVE_LIMIT) && queue non-empty. This is combinational from registered state.
- **Grant, per cycle, in priority order:**
  1. **STALL** (pipe_stall=1): grant the queue head; pipeline inputs are ignored; starve_cnt ← 0.
  2. **PIPE** (pipe_wr_en=1): write the pipeline result. Data = alu_op_in if sel=0, ld_op_in if sel=1. If the queue is non-empty, starve_cnt increments, saturating at STARVE_LIMIT.
  3. **CX** (queue non-empty): grant the queue head; starve_cnt ← 0.
  4. **IDLE:** no write; starve_cnt ← 0.
- **Head grant:** pops the head.
  - If the head is valid, register a write.
  - If the head is invalidated, pop it with no write (rf_we=0 next cycle).
- **Ordering rule:** on a PIPE grant, every queued entry whose rd == pipe_rd has its valid bit cleared the same edge. This prevents an older accelerator result from overwriting a newer pipeline value.
  - An entry pushed in the same cycle with cx_rd == pipe_rd is not cleared.
- **Reset:** queue emptied, pointers and count 0, starve_cnt 0, rf_we/rf_waddr/rf_wdata 0. This gives cx_ready=1 and pipe_stall=0 the cycle after reset.
  - Reset asserted mid-operation discards all queued results without writing them.

## Timing
- **Latency:** granted request at cycle N → rf_we/rf_waddr/rf_wdata valid at cycle N+1, held for exactly one cycle.
- **Accelerator result path:**
  - Accepted at cycle N, queue empty, no pipeline writes → rf write visible at N+2 (grant at N+1).
  - Throughput is at most one rf write per cycle.
- **Stall:**
  - pipe_stall is asserted for one cycle per starvation event.
  - The next pipeline write can be granted the following cycle.
  - The upstream pipeline keeps pipe_wr_en, pipe_rd and data stable while pipe_stall=1.
- **Stall cadence under sustained pipeline writes:** with a non-empty queue, the pipeline gets STARVE_LIMIT writes, then 1 stall cycle, repeating.
- **Simultaneous events:**
  - Push and pop in the same cycle (not full): count unchanged.
  - Push while a full queue pops: push refused, since cx_ready was 0.

## Test plan
- **Reset:** hold rst 2 cycles with random inputs → rf_we=0, rf_waddr=0, rf_wdata=0, cx_ready=1, pipe_stall=0.
- **Mux select:** pipe_wr_en=1, pipe_rd=3, alu=0x1234, ld=0xBEEF.
  - sel=0 → next cycle rf_we=1, addr 3, data 0x1234.
  - sel=1 → next cycle rf_we=1, addr 3, data 0xBEEF.
- **Accelerator path:** cx_valid for one cycle (rd=5, data=0xA5A5), no pipeline traffic → rf write {5, 0xA5A5} exactly two cycles later, once.
- **Starvation:**
  - Queue one entry (rd=6, 0x0F0F), then pipe_wr_en=1 continuously with STARVE_LIMIT=4.
  - Required: 4 pipeline writes, then pipe_stall=1 for one cycle, then rf write {6, 0x0F0F}, then pipeline writes resume with the held data.
- **Full / backpressure:**
  - With the pipeline writing continuously, push 3 results with CQ_DEPTH=2 → cx_ready=0 after 2 accepts, third held.
  - Required: all three written in push order, none lost.
- **Ordering drop:**
  - Queue {rd=2, 0x1111}, then a pipeline write rd=2, 0x2222 while the queue is non-empty.
  - Required: register 2 written 0x2222 only; the queued entry pops with rf_we=0.
  - Apply rst while 2 entries are queued → no writes after reset.
